// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: serialises one CPU word load/store into narrow SRAM beats
// with programmable wait states, freezing the pipeline until the access completes.
module mem_stage_sram_ctrl #(
  parameter int WORD_W    = 32,
  parameter int SRAM_DW   = 16,
  parameter int SRAM_AW   = 18,
  parameter int WAIT_CYC  = 1,
  parameter int BASE_ADDR = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [WORD_W-1:0]  alu_result,
  input  logic [WORD_W-1:0]  write_data,
  output logic [WORD_W-1:0]  read_data,
  output logic [WORD_W-1:0]  wb_data,
  output logic               stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  inout  wire  [SRAM_DW-1:0] sram_dq
);

  localparam int BEATS      = WORD_W / SRAM_DW;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SHIFT = $clog2(WORD_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYC);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_next;
  logic                op_write;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   rd_buf, rd_buf_next;
  logic [SRAM_AW-1:0]  base_q, req_base;
  logic [BEAT_W-1:0]   beat;
  logic [3:0]          wait_cnt;
  logic                req, beat_end, drive_dq;

  assign req      = mem_r_en | mem_w_en;
  assign req_base = SRAM_AW'(((alu_result - WORD_W'(BASE_ADDR)) >> BYTE_SHIFT) * WORD_W'(BEATS));
  assign beat_end = (state == ACCESS) && (wait_cnt == WAIT_LAST);
  assign drive_dq = (state == ACCESS) && op_write;
  assign sram_dq  = drive_dq ? wdata_q[int'(beat)*SRAM_DW +: SRAM_DW] : {SRAM_DW{1'bz}};
  assign wb_data  = mem_r_en ? read_data : alu_result;

  always_comb begin
    rd_buf_next = rd_buf;
    rd_buf_next[int'(beat)*SRAM_DW +: SRAM_DW] = sram_dq;
  end

  // Stall is gated by reset so a pending request cannot freeze the pipe while held in reset
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    unique case (state)
      IDLE: begin
        stall = req & rst;
        if (req) state_next = ACCESS;
      end
      ACCESS: begin
        stall = 1'b1;
        if (beat_end && beat == LAST_BEAT) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // SRAM address and write strobe are registered one cycle ahead of the beat they serve
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_write  <= 1'b0;
      wdata_q   <= '0;
      base_q    <= '0;
      beat      <= '0;
      wait_cnt  <= '0;
      rd_buf    <= '0;
      read_data <= '0;
      sram_addr <= '0;
      sram_we_n <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            op_write  <= mem_w_en;
            wdata_q   <= write_data;
            base_q    <= req_base;
            beat      <= '0;
            wait_cnt  <= '0;
            sram_addr <= req_base;
            sram_we_n <= ~mem_w_en;
          end
        end
        ACCESS: begin
          if (beat_end) begin
            wait_cnt <= '0;
            if (!op_write) rd_buf <= rd_buf_next;
            if (beat == LAST_BEAT) begin
              beat      <= '0;
              sram_we_n <= 1'b1;
              if (!op_write) read_data <= rd_buf_next;
            end else begin
              beat      <= beat + 1'b1;
              sram_addr <= base_q + SRAM_AW'(beat + 1'b1);
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl: default instance with SRAM model plus two
// parameter-sweep instances checked for stall length and beat sequencing.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // default instance
  logic        a_r_en = 0, a_w_en = 0;
  logic [31:0] a_alu = 0, a_wdata = 0;
  logic [31:0] a_rdata, a_wb;
  logic        a_stall, a_we_n;
  logic [17:0] a_addr;
  wire  [15:0] a_dq;
  logic [15:0] a_mem [0:(1<<18)-1];

  mem_stage_sram_ctrl u_a (
    .clk(clk), .rst(rst), .mem_r_en(a_r_en), .mem_w_en(a_w_en),
    .alu_result(a_alu), .write_data(a_wdata), .read_data(a_rdata), .wb_data(a_wb),
    .stall(a_stall), .sram_addr(a_addr), .sram_we_n(a_we_n), .sram_dq(a_dq)
  );

  assign a_dq = a_we_n ? a_mem[a_addr] : 16'bz;

  always @(negedge clk) begin
    if (!a_we_n) a_mem[a_addr] = a_dq;
  end

  // WAIT_CYC = 0 instance
  logic        b_w_en = 0;
  logic [31:0] b_alu = 0, b_wdata = 0;
  logic [31:0] b_rdata, b_wb;
  logic        b_stall, b_we_n;
  logic [17:0] b_addr;
  wire  [15:0] b_dq;

  mem_stage_sram_ctrl #(.WAIT_CYC(0)) u_b (
    .clk(clk), .rst(rst), .mem_r_en(1'b0), .mem_w_en(b_w_en),
    .alu_result(b_alu), .write_data(b_wdata), .read_data(b_rdata), .wb_data(b_wb),
    .stall(b_stall), .sram_addr(b_addr), .sram_we_n(b_we_n), .sram_dq(b_dq)
  );

  // 64-bit word, 4 beats, 3 cycles per beat
  logic        c_w_en = 0;
  logic [63:0] c_alu = 0, c_wdata = 0;
  logic [63:0] c_rdata, c_wb;
  logic        c_stall, c_we_n;
  logic [17:0] c_addr;
  wire  [15:0] c_dq;

  mem_stage_sram_ctrl #(.WORD_W(64), .SRAM_DW(16), .WAIT_CYC(2)) u_c (
    .clk(clk), .rst(rst), .mem_r_en(1'b0), .mem_w_en(c_w_en),
    .alu_result(c_alu), .write_data(c_wdata), .read_data(c_rdata), .wb_data(c_wb),
    .stall(c_stall), .sram_addr(c_addr), .sram_we_n(c_we_n), .sram_dq(c_dq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] wb;
    int          stall_cyc;
  } done_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] dq;
  } beat_t;

  done_t done_q[$];
  beat_t beat_q[$];
  bit    mon_en    = 0;
  int    stall_run = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: write beats are checked every cycle, completions when stall falls
  always @(negedge clk) begin
    if (!mon_en || !rst) begin
      stall_run = 0;
    end else begin
      if (!a_we_n) begin
        if (beat_q.size() == 0) begin
          check_output("unexpected_write_beat", {46'd0, a_addr}, 64'h3_FFFF_FFFF);
        end else begin
          beat_t eb;
          eb = beat_q.pop_front();
          check_output("beat_addr", a_addr, eb.addr);
          check_output("beat_dq", a_dq, eb.dq);
        end
      end
      if (a_stall) begin
        stall_run++;
      end else if (stall_run != 0) begin
        if (done_q.size() == 0) begin
          check_output("unexpected_completion", stall_run, 0);
        end else begin
          done_t ed;
          ed = done_q.pop_front();
          check_output("stall_cycles", stall_run, ed.stall_cyc);
          check_output("read_data", a_rdata, ed.rdata);
          check_output("wb_data", a_wb, ed.wb);
        end
        stall_run = 0;
      end
    end
  end

  // Called one step after a rising edge; holds the request through DONE
  task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input int exp_stall, input logic [17:0] base);
    done_q.push_back('{exp_rdata, r ? exp_rdata : addr, exp_stall});
    if (w) begin
      beat_q.push_back('{base, wdata[15:0]});
      beat_q.push_back('{base, wdata[15:0]});
      beat_q.push_back('{base + 18'd1, wdata[31:16]});
      beat_q.push_back('{base + 18'd1, wdata[31:16]});
    end
    a_r_en  = r;
    a_w_en  = w;
    a_alu   = addr;
    a_wdata = wdata;
    repeat (exp_stall + 1) @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input logic [31:0] alu);
    a_r_en = 0;
    a_w_en = 0;
    a_alu  = alu;
  endtask

  logic [15:0] c_exp [4];

  initial begin
    a_mem[0] = 16'h2222;
    a_mem[4] = 16'h5678;
    a_mem[5] = 16'h1234;
    c_exp    = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    #12;
    check_output("rst_read_data", a_rdata, 0);
    check_output("rst_sram_addr", a_addr, 0);
    check_output("rst_we_n", a_we_n, 1);
    check_output("rst_stall", a_stall, 0);
    check_output("rst_dq_released", a_dq, 16'h2222);
    rst = 1;
    @(posedge clk); #1;
    mon_en = 1;

    a_alu = 32'h77;
    #1;
    check_output("nonmem_stall", a_stall, 0);
    check_output("nonmem_wb", a_wb, 32'h77);

    apply_stimulus(1, 0, 32'd1032, 32'h0, 32'h1234_5678, 5, 18'd0);
    go_idle(32'h99);
    repeat (3) @(posedge clk); #1;
    check_output("load_held", a_rdata, 32'h1234_5678);
    check_output("idle_wb", a_wb, 32'h99);
    check_output("idle_stall", a_stall, 0);

    apply_stimulus(0, 1, 32'd1032, 32'hDEAD_BEEF, 32'h1234_5678, 5, 18'd4);
    apply_stimulus(1, 0, 32'd1032, 32'h0, 32'hDEAD_BEEF, 5, 18'd0);
    apply_stimulus(1, 1, 32'd1040, 32'hCAFE_F00D, 32'hDEAD_BEEF, 5, 18'd8);
    apply_stimulus(1, 0, 32'd1040, 32'h0, 32'hCAFE_F00D, 5, 18'd0);
    apply_stimulus(0, 1, 32'd525312, 32'h1111_2222, 32'hCAFE_F00D, 5, 18'd0);
    go_idle(32'h0);
    @(posedge clk); #1;

    mon_en = 0;
    a_w_en = 1; a_alu = 32'd1032; a_wdata = 32'h0BAD_0BAD;
    repeat (2) @(posedge clk); #1;
    check_output("pre_rst_we_n", a_we_n, 0);
    rst = 0;
    #1;
    check_output("midrst_we_n", a_we_n, 1);
    check_output("midrst_dq_released", a_dq, 16'h2222);
    check_output("midrst_stall", a_stall, 0);
    check_output("midrst_read_data", a_rdata, 0);
    @(posedge clk); #1;
    a_w_en = 0;
    rst = 1;
    #1;
    check_output("post_rst_stall", a_stall, 0);
    mon_en = 1;
    apply_stimulus(1, 0, 32'd1040, 32'h0, 32'hCAFE_F00D, 5, 18'd0);
    go_idle(32'h0);
    repeat (2) @(posedge clk); #1;
    mon_en = 0;

    begin
      int run = 0, wcnt = 0;
      bit seen = 0;
      b_alu = 32'd1032; b_wdata = 32'hA5A5_5A5A; b_w_en = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!b_we_n) begin
          check_output("b_beat_addr", b_addr, (wcnt == 0) ? 18'd4 : 18'd5);
          check_output("b_beat_dq", b_dq, (wcnt == 0) ? 16'h5A5A : 16'hA5A5);
          wcnt++;
        end
        if (b_stall) begin
          run++;
          seen = 1;
        end else if (seen) begin
          break;
        end
      end
      b_w_en = 0;
      check_output("b_stall_cycles", run, 3);
      check_output("b_write_cycles", wcnt, 2);
    end

    @(posedge clk); #1;
    begin
      int run = 0, wcnt = 0;
      bit seen = 0;
      c_alu = 64'd1048; c_wdata = 64'h4444_3333_2222_1111; c_w_en = 1;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (!c_we_n && wcnt < 12) begin
          check_output("c_beat_addr", c_addr, 18'(12 + wcnt / 3));
          check_output("c_beat_dq", c_dq, c_exp[wcnt / 3]);
          wcnt++;
        end
        if (c_stall) begin
          run++;
          seen = 1;
        end else if (seen) begin
          break;
        end
      end
      c_w_en = 0;
      check_output("c_stall_cycles", run, 13);
      check_output("c_write_cycles", wcnt, 12);
    end

    repeat (2) @(posedge clk);
    check_output("pending_completions", done_q.size(), 0);
    check_output("pending_beats", beat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
